// File: rtl/phy_tx_lane_serializer.sv
// Transmit serializer: time-division multiplexes LANES byte channels onto one
// serial line with comma bring-up and frame-aligned resynchronisation.
//
// state  | meaning
// SYNC   | sending COM symbols so the receiver can find symbol/frame alignment
// ACTIVE | one slot per lane in turn; IDLE when the lane is masked or empty
module phy_tx_lane_serializer #(
    parameter int               LANES     = 4,
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] COM       = 8'hBC,
    parameter logic [WIDTH-1:0] IDLE      = 8'h7C,
    parameter int               COM_COUNT = 4
) (
    input  logic                   clk_32f,
    input  logic                   default_values,
    input  logic [LANES*WIDTH-1:0] data_in,
    input  logic [LANES-1:0]       valid_in,
    input  logic [LANES-1:0]       lane_en,
    input  logic                   resync,
    output logic [LANES-1:0]       ready_out,
    output logic                   data_out,
    output logic                   active,
    output logic                   idle_out
);

    localparam int BCW = $clog2(WIDTH);
    localparam int LPW = $clog2(LANES);
    localparam int CCW = (COM_COUNT > 1) ? $clog2(COM_COUNT) : 1;

    typedef enum logic {SYNC, ACTIVE} state_t;

    state_t           state_q, state_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [LPW-1:0]   lane_ptr_q, lane_ptr_d;
    logic [CCW-1:0]   com_cnt_q, com_cnt_d;
    logic [CCW-1:0]   com_base;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [LANES-1:0] lane_en_q, lane_en_d;
    logic [LANES-1:0] mask_eff;
    logic             sync_done_q, sync_done_d;
    logic             resync_pend_q, resync_pend_d;
    logic             first_q, first_d;
    logic             idle_q, idle_d;
    logic             active_q, active_d;
    logic [WIDTH-1:0] sym;
    logic [WIDTH-1:0] lane_byte;
    logic             load;
    logic             frame_start;

    assign load        = first_q || (bit_cnt_q == BCW'(WIDTH - 1));
    assign frame_start = (lane_ptr_q == '0);
    assign lane_byte   = data_in[lane_ptr_q*WIDTH +: WIDTH];
    // The frame's mask is taken live at slot 0 so lane 0 obeys the new mask too.
    assign mask_eff    = frame_start ? lane_en : lane_en_q;

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q + 1'b1;
        lane_ptr_d    = lane_ptr_q;
        com_cnt_d     = com_cnt_q;
        com_base      = com_cnt_q;
        sync_done_d   = sync_done_q;
        lane_en_d     = lane_en_q;
        first_d       = 1'b0;
        shift_d       = {shift_q[WIDTH-2:0], 1'b0};
        idle_d        = idle_q;
        active_d      = active_q;
        resync_pend_d = (state_q == ACTIVE) && (resync_pend_q || resync);
        ready_out     = '0;
        sym           = IDLE;
        if (load) begin
            bit_cnt_d = '0;
            if ((state_q == SYNC && !sync_done_q) ||
                (state_q == ACTIVE && frame_start && resync_pend_q)) begin
                sym           = COM;
                state_d       = SYNC;
                active_d      = 1'b0;
                lane_ptr_d    = '0;
                resync_pend_d = 1'b0;
                if (state_q == ACTIVE) begin
                    com_base = '0;
                end
                if (com_base == CCW'(COM_COUNT - 1)) begin
                    sync_done_d = 1'b1;
                    com_cnt_d   = '0;
                end else begin
                    com_cnt_d = com_base + 1'b1;
                end
            end else begin
                state_d     = ACTIVE;
                active_d    = 1'b1;
                sync_done_d = 1'b0;
                if (frame_start) begin
                    lane_en_d = lane_en;
                end
                if (mask_eff[lane_ptr_q] && valid_in[lane_ptr_q]) begin
                    sym                   = lane_byte;
                    ready_out[lane_ptr_q] = 1'b1;
                end
                lane_ptr_d = (lane_ptr_q == LPW'(LANES - 1)) ? '0 : lane_ptr_q + 1'b1;
            end
            shift_d = sym;
            idle_d  = (sym == IDLE);
        end
    end

    always_ff @(posedge clk_32f or negedge default_values) begin
        if (!default_values) begin
            state_q       <= SYNC;
            bit_cnt_q     <= '0;
            lane_ptr_q    <= '0;
            com_cnt_q     <= '0;
            sync_done_q   <= 1'b0;
            lane_en_q     <= '0;
            first_q       <= 1'b1;
            shift_q       <= '0;
            idle_q        <= 1'b0;
            active_q      <= 1'b0;
            resync_pend_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            lane_ptr_q    <= lane_ptr_d;
            com_cnt_q     <= com_cnt_d;
            sync_done_q   <= sync_done_d;
            lane_en_q     <= lane_en_d;
            first_q       <= first_d;
            shift_q       <= shift_d;
            idle_q        <= idle_d;
            active_q      <= active_d;
            resync_pend_q <= resync_pend_d;
        end
    end

    assign data_out = shift_q[WIDTH-1];
    assign active   = active_q;
    assign idle_out = idle_q;

endmodule

// File: tb/tb_phy_tx_lane_serializer.sv
// Directed bench for phy_tx_lane_serializer: default 4-lane instance plus a
// 3-lane, 10-bit instance for non-power-of-two wrap.
module tb_phy_tx_lane_serializer;

    logic        clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    logic        default_values;
    logic [31:0] data_in;
    logic [3:0]  valid_in;
    logic [3:0]  lane_en;
    logic        resync;
    logic [3:0]  ready_out;
    logic        data_out;
    logic        active;
    logic        idle_out;

    logic        rst3_n;
    logic [29:0] data3;
    logic [2:0]  valid3;
    logic [2:0]  en3;
    logic        resync3;
    logic [2:0]  ready3;
    logic        dout3;
    logic        active3;
    logic        idle3;

    int n_cmp = 0;
    int n_bad = 0;

    phy_tx_lane_serializer dut (
        .clk_32f        (clk_32f),
        .default_values (default_values),
        .data_in        (data_in),
        .valid_in       (valid_in),
        .lane_en        (lane_en),
        .resync         (resync),
        .ready_out      (ready_out),
        .data_out       (data_out),
        .active         (active),
        .idle_out       (idle_out)
    );

    phy_tx_lane_serializer #(
        .LANES(3), .WIDTH(10), .COM(10'h17C), .IDLE(10'h0FA), .COM_COUNT(4)
    ) dut3 (
        .clk_32f        (clk_32f),
        .default_values (rst3_n),
        .data_in        (data3),
        .valid_in       (valid3),
        .lane_en        (en3),
        .resync         (resync3),
        .ready_out      (ready3),
        .data_out       (dout3),
        .active         (active3),
        .idle_out       (idle3)
    );

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_32f);
        #1;
    endtask

    // Called in a load cycle; returns after one full symbol, again in a load cycle.
    task automatic run_sym(input logic [3:0] new_en, input logic do_resync,
                           output logic [7:0] sym, output logic [3:0] rdy,
                           output logic act, output logic idl, output logic stray);
        rdy = ready_out;
        sym = '0; stray = 1'b0; act = 1'b0; idl = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (b == 3) begin
                lane_en = new_en;
                resync  = do_resync;
            end
            if (b == 4) resync = 1'b0;
            tick();
            if (b == 0) begin
                act = active;
                idl = idle_out;
            end else if (active !== act || idle_out !== idl) begin
                stray = 1'b1;
            end
            if (b < 7 && ready_out !== 4'b0) stray = 1'b1;
            sym = {sym[6:0], data_out};
        end
    endtask

    task automatic run_sym3(output logic [9:0] sym, output logic [2:0] rdy,
                            output logic act, output logic idl, output logic stray);
        rdy = ready3;
        sym = '0; stray = 1'b0; act = 1'b0; idl = 1'b0;
        for (int b = 0; b < 10; b++) begin
            tick();
            if (b == 0) begin
                act = active3;
                idl = idle3;
            end else if (active3 !== act || idle3 !== idl) begin
                stray = 1'b1;
            end
            if (b < 9 && ready3 !== 3'b0) stray = 1'b1;
            sym = {sym[8:0], dout3};
        end
    endtask

    task automatic bring_up();
        logic [7:0] s; logic [3:0] r; logic a, i, st;
        resync = 1'b0;
        default_values = 1'b0;
        tick();
        tick();
        default_values = 1'b1;
        n_cmp++;
        if (ready_out !== 4'b0) begin
            n_bad++;
            $display("FAIL bring_up_first_ready: got %b want 0000", ready_out);
        end
        for (int k = 0; k < 4; k++) begin
            run_sym(lane_en, 1'b0, s, r, a, i, st);
            n_cmp++;
            if ({s, r, a, i, st} !== {8'hBC, 4'b0, 1'b0, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL bring_up_com %0d: got sym=%h rdy=%b act=%b idle=%b stray=%b want sym=bc rdy=0000 act=0 idle=0 stray=0",
                         k, s, r, a, i, st);
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] s; logic [3:0] r; logic a, i, st;
        lane_en = 4'hF; valid_in = 4'h0; data_in = 32'h44332211;
        default_values = 1'b0;
        tick();
        n_cmp++;
        if ({data_out, active, idle_out, ready_out} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got dout=%b act=%b idle=%b rdy=%b want all 0",
                     data_out, active, idle_out, ready_out);
        end
        bring_up();
        for (int k = 0; k < 3; k++) begin
            run_sym(lane_en, 1'b0, s, r, a, i, st);
            n_cmp++;
            if ({s, r, a, i, st} !== {8'h7C, 4'b0, 1'b1, 1'b1, 1'b0}) begin
                n_bad++;
                $display("FAIL idle_stream %0d: got sym=%h rdy=%b act=%b idle=%b stray=%b want sym=7c rdy=0000 act=1 idle=1 stray=0",
                         k, s, r, a, i, st);
            end
        end
    endtask

    task automatic test_all_lanes();
        logic [7:0] s; logic [3:0] r; logic a, i, st;
        logic [7:0] eb [4];
        eb = '{8'h11, 8'h22, 8'h33, 8'h44};
        lane_en = 4'hF; valid_in = 4'hF; data_in = 32'h44332211;
        bring_up();
        for (int k = 0; k < 8; k++) begin
            run_sym(lane_en, 1'b0, s, r, a, i, st);
            n_cmp++;
            if ({s, r, a, i, st} !== {eb[k%4], 4'(1 << (k%4)), 1'b1, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL all_lanes slot %0d: got sym=%h rdy=%b act=%b idle=%b stray=%b want sym=%h rdy=%b act=1 idle=0 stray=0",
                         k, s, r, a, i, st, eb[k%4], 4'(1 << (k%4)));
            end
        end
    endtask

    task automatic test_lane_mask();
        logic [7:0] s; logic [3:0] r; logic a, i, st;
        logic [7:0] eb [8];
        logic [3:0] er [8];
        logic       ei [8];
        eb = '{8'h11, 8'h7C, 8'h33, 8'h7C, 8'h11, 8'h22, 8'h33, 8'h44};
        er = '{4'b0001, 4'b0000, 4'b0100, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        ei = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        lane_en = 4'b0101; valid_in = 4'hF; data_in = 32'h44332211;
        bring_up();
        for (int k = 0; k < 8; k++) begin
            run_sym((k == 1) ? 4'hF : lane_en, 1'b0, s, r, a, i, st);
            n_cmp++;
            if ({s, r, a, i, st} !== {eb[k], er[k], 1'b1, ei[k], 1'b0}) begin
                n_bad++;
                $display("FAIL lane_mask slot %0d: got sym=%h rdy=%b act=%b idle=%b stray=%b want sym=%h rdy=%b act=1 idle=%b stray=0",
                         k, s, r, a, i, st, eb[k], er[k], ei[k]);
            end
        end
    endtask

    task automatic test_resync();
        logic [7:0] s; logic [3:0] r; logic a, i, st;
        logic [7:0] eb [12];
        logic [3:0] er [12];
        logic       ea [12];
        eb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hBC, 8'hBC, 8'hBC, 8'hBC,
               8'h11, 8'h22, 8'h33, 8'h44};
        er = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0, 4'b0, 4'b0, 4'b0,
               4'b0001, 4'b0010, 4'b0100, 4'b1000};
        ea = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
               1'b1, 1'b1, 1'b1, 1'b1};
        lane_en = 4'hF; valid_in = 4'hF; data_in = 32'h44332211;
        bring_up();
        for (int k = 0; k < 12; k++) begin
            run_sym(lane_en, (k == 1), s, r, a, i, st);
            n_cmp++;
            if ({s, r, a, i, st} !== {eb[k], er[k], ea[k], 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL resync slot %0d: got sym=%h rdy=%b act=%b idle=%b stray=%b want sym=%h rdy=%b act=%b idle=0 stray=0",
                         k, s, r, a, i, st, eb[k], er[k], ea[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] s; logic [3:0] r; logic a, i, st;
        lane_en = 4'hF; valid_in = 4'hF; data_in = 32'h44332211;
        bring_up();
        run_sym(lane_en, 1'b0, s, r, a, i, st);
        tick(); tick(); tick();
        n_cmp++;
        if ({data_out, active} !== 2'b11) begin
            n_bad++;
            $display("FAIL mid_symbol_before_reset: got dout=%b act=%b want dout=1 act=1", data_out, active);
        end
        #2;
        default_values = 1'b0;
        #1;
        n_cmp++;
        if ({data_out, active, idle_out, ready_out} !== 7'b0) begin
            n_bad++;
            $display("FAIL mid_symbol_reset: got dout=%b act=%b idle=%b rdy=%b want all 0",
                     data_out, active, idle_out, ready_out);
        end
        bring_up();
        run_sym(lane_en, 1'b0, s, r, a, i, st);
        n_cmp++;
        if ({s, r, a, i, st} !== {8'h11, 4'b0001, 1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL restart_first_slot: got sym=%h rdy=%b act=%b idle=%b stray=%b want sym=11 rdy=0001 act=1 idle=0 stray=0",
                     s, r, a, i, st);
        end
    endtask

    task automatic test_three_lanes();
        logic [9:0] s; logic [2:0] r; logic a, i, st;
        logic [9:0] eb [10];
        logic [2:0] er [10];
        logic       ea [10];
        logic       ei [10];
        eb = '{10'h17C, 10'h17C, 10'h17C, 10'h17C,
               10'h2AB, 10'h0FA, 10'h3C1, 10'h2AB, 10'h0FA, 10'h3C1};
        er = '{3'b0, 3'b0, 3'b0, 3'b0, 3'b001, 3'b000, 3'b100, 3'b001, 3'b000, 3'b100};
        ea = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        ei = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        data3 = {10'h3C1, 10'h155, 10'h2AB};
        valid3 = 3'b101; en3 = 3'b111; resync3 = 1'b0;
        rst3_n = 1'b0;
        tick();
        tick();
        rst3_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            run_sym3(s, r, a, i, st);
            n_cmp++;
            if ({s, r, a, i, st} !== {eb[k], er[k], ea[k], ei[k], 1'b0}) begin
                n_bad++;
                $display("FAIL three_lanes slot %0d: got sym=%h rdy=%b act=%b idle=%b stray=%b want sym=%h rdy=%b act=%b idle=%b stray=0",
                         k, s, r, a, i, st, eb[k], er[k], ea[k], ei[k]);
            end
        end
    endtask

    initial begin
        default_values = 1'b0;
        data_in = '0; valid_in = '0; lane_en = '0; resync = 1'b0;
        rst3_n = 1'b0;
        data3 = '0; valid3 = '0; en3 = '0; resync3 = 1'b0;
        test_reset();
        test_all_lanes();
        test_lane_mask();
        test_resync();
        test_reset_mid();
        test_three_lanes();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
